idp_enc20_arbiter: RTL and testbench

- Shares one IDP_encoder_20 instance among N_CH requester channels.
- Round-robin arbitration; at most one accept per cycle; channel tag carried alongside the encoder's 1-cycle registered latency.
- Finished codewords buffered in an OBUF_D-entry output FIFO. Issue is credit-gated, so codewords are never lost, even though the encoder has no enable and no reset.
- Sits between the parallel-bus packetiser channels and the 20-wire CAC link driver.

---
 rtl/idp_enc20_arbiter.sv | 150 +++++++++++++++
 tb/tb_idp_enc20_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/idp_enc20_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : idp_enc20_arbiter
// Description : Round-robin sharing of one 20-wire encoder among N_CH
//               requesters. Channel tags follow the encoder's registered
//               latency, and finished codewords land in a small output FIFO.
//               Issue is credit-gated so that no codeword can be dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module idp_enc20_arbiter #(
    parameter int DIN_W  = 16,   // encoder input word width
    parameter int N_CH   = 4,    // requester channels, >= 2
    parameter int OBUF_D = 4,    // output FIFO depth, power of 2, >= 3
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_CH-1:0]         req_valid,
    input  logic [N_CH*DIN_W-1:0]   req_data,
    output logic [N_CH-1:0]         req_ready,
    output logic [DIN_W-1:0]        enc_datain,
    input  logic [19:0]             enc_codeout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [19:0]             out_code,
    output logic [CH_W-1:0]         out_chan,
    output logic                    busy
);

    localparam int AW = $clog2(OBUF_D);
    localparam logic [CH_W:0] c_nch   = (CH_W+1)'(N_CH);
    localparam logic [CH_W-1:0] c_last = CH_W'(N_CH - 1);
    localparam logic [AW+1:0] c_depth = (AW+2)'(OBUF_D);
    localparam logic [AW:0]   c_full  = (AW+1)'(OBUF_D);

    // Arbitration and pipeline state
    logic [CH_W-1:0]  r_ptr;
    logic             r_va;
    logic             r_vb;
    logic [CH_W-1:0]  r_tag_a;
    logic [CH_W-1:0]  r_tag_b;
    logic [DIN_W-1:0] r_enc_datain;

    // Output FIFO state
    logic [19:0]      r_fifo_code [OBUF_D];
    logic [CH_W-1:0]  r_fifo_chan [OBUF_D];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Combinational helpers
    logic [AW+1:0]    w_occ;
    logic             w_credit_ok;
    logic [CH_W:0]    w_sum;
    logic             w_grant_any;
    logic [CH_W-1:0]  w_grant_idx;
    logic [CH_W-1:0]  w_ptr_next;
    logic             w_push;
    logic             w_pop;

    // Words accepted but not yet popped; a pop in this cycle is deliberately not credited
    always_comb begin
        w_occ       = {1'b0, r_count} + {{(AW+1){1'b0}}, r_va} + {{(AW+1){1'b0}}, r_vb};
        w_credit_ok = (w_occ < c_depth);
    end

    // Round-robin search from r_ptr; descending loop so the nearest channel wins
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (CH_W+1)'(k);
            if (w_sum >= c_nch) begin
                w_sum = w_sum - c_nch;
            end
            if (req_valid[w_sum[CH_W-1:0]] && w_credit_ok && !reset) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_sum[CH_W-1:0];
            end
        end
        w_ptr_next = (w_grant_idx == c_last) ? '0 : (w_grant_idx + 1'b1);
        req_ready  = w_grant_any ? (N_CH'(1) << w_grant_idx) : '0;
    end

    // Stage A captures the granted word; stage B tracks the encoder's internal register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr        <= '0;
            r_va         <= 1'b0;
            r_vb         <= 1'b0;
            r_tag_a      <= '0;
            r_tag_b      <= '0;
            r_enc_datain <= '0;
        end else begin
            r_vb    <= r_va;
            r_tag_b <= r_tag_a;
            r_va    <= w_grant_any;
            if (w_grant_any) begin
                r_ptr        <= w_ptr_next;
                r_tag_a      <= w_grant_idx;
                r_enc_datain <= req_data[int'(w_grant_idx)*DIN_W +: DIN_W];
            end
        end
    end

    assign w_push = r_vb;
    assign w_pop  = out_valid & out_ready;

    // FIFO storage; contents need no reset since r_count gates visibility
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_code[r_wr_ptr] <= enc_codeout;
            r_fifo_chan[r_wr_ptr] <= r_tag_b;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A push into a full FIFO would mean the credit scheme is broken
    a_no_overflow : assert property (@(posedge clock) disable iff (reset)
        !(w_push && (r_count == c_full)));

    assign enc_datain = r_enc_datain;
    assign out_valid  = (r_count != '0);
    assign out_code   = r_fifo_code[r_rd_ptr];
    assign out_chan   = r_fifo_chan[r_rd_ptr];
    assign busy       = r_va | r_vb | (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_idp_enc20_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_idp_enc20_arbiter
// Description : Scoreboard bench for idp_enc20_arbiter with a stand-in
//               registered encoder and a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idp_enc20_arbiter;

    localparam int DIN_W  = 16;
    localparam int N_CH   = 4;
    localparam int OBUF_D = 4;
    localparam int CH_W   = $clog2(N_CH);

    logic                  clock;
    logic                  reset;
    logic [N_CH-1:0]       req_valid;
    logic [N_CH*DIN_W-1:0] req_data;
    logic [N_CH-1:0]       req_ready;
    logic [DIN_W-1:0]      enc_datain;
    logic [19:0]           enc_codeout;
    logic                  out_valid;
    logic                  out_ready;
    logic [19:0]           out_code;
    logic [CH_W-1:0]       out_chan;
    logic                  busy;

    idp_enc20_arbiter #(.DIN_W(DIN_W), .N_CH(N_CH), .OBUF_D(OBUF_D)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .enc_datain  (enc_datain),
        .enc_codeout (enc_codeout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .out_chan    (out_chan),
        .busy        (busy)
    );

    // Stand-in encoder mapping: any fixed injective 16->20 function will do
    function automatic logic [19:0] enc_fn(input logic [DIN_W-1:0] d);
        enc_fn = {^d, d[15:13] ^ d[2:0], d};
    endfunction

    // Stand-in encoder: one register stage, no enable, no reset
    always @(posedge clock) enc_codeout <= enc_fn(enc_datain);

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [19:0] code;
        int          chan;
        longint      avail;
    } exp_t;

    exp_t   sb[$];
    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    int     m_ptr    = 0;
    int     accepts  = 0;
    int     pops     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Model: predict grant from pointer, pending requests and outstanding words
    always @(negedge clock) begin
        int g;
        logic [N_CH-1:0] exp_rr;
        #2;
        if (reset) begin
            checks++;
            if (req_ready !== '0) begin
                failures++;
                $display("FAIL req_ready_in_reset cyc=%0d got=%b exp=0", cyc, req_ready);
            end
            sb.delete();
            m_ptr   = 0;
            accepts = 0;
            pops    = 0;
        end else begin
            checks++;
            if (busy !== ((accepts - pops) != 0)) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%0d", cyc, busy, (accepts - pops) != 0);
            end
            g = -1;
            if ((accepts - pops) < OBUF_D) begin
                for (int k = 0; k < N_CH; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % N_CH]) g = (m_ptr + k) % N_CH;
                end
            end
            exp_rr = '0;
            if (g >= 0) exp_rr[g] = 1'b1;
            checks++;
            if (req_ready !== exp_rr) begin
                failures++;
                $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rr);
            end
            if (g >= 0) begin
                sb.push_back('{enc_fn(req_data[g*DIN_W +: DIN_W]), g, cyc + 3});
                accepts++;
                m_ptr = (g + 1) % N_CH;
            end
        end
    end

    // Monitor: compare the FIFO head against the scoreboard and retire on pop
    always @(negedge clock) begin
        logic exp_v;
        #3;
        if (!reset) begin
            exp_v = (sb.size() > 0) && (sb[0].avail <= cyc);
            checks++;
            if (out_valid !== exp_v) begin
                failures++;
                $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v);
            end
            if (exp_v && out_valid) begin
                checks++;
                if (out_code !== sb[0].code || int'(out_chan) != sb[0].chan) begin
                    failures++;
                    $display("FAIL out_word cyc=%0d got=%h/ch%0d exp=%h/ch%0d",
                             cyc, out_code, out_chan, sb[0].code, sb[0].chan);
                end
            end
            if (exp_v && out_ready) begin
                void'(sb.pop_front());
                pops++;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [N_CH-1:0] acc;

    // Requesters hold valid/data until accepted; new requests drawn from mask
    task automatic run(input int n, input logic [N_CH-1:0] mask, input int vpct, input int rpct);
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            for (int i = 0; i < N_CH; i++) begin
                if (!(req_valid[i] && !acc[i])) begin
                    req_valid[i] = mask[i] && ($urandom_range(0, 99) < vpct);
                    if (req_valid[i]) req_data[i*DIN_W +: DIN_W] = DIN_W'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 99) < rpct);
            #4;
            acc = req_valid & req_ready;
        end
    endtask

    task automatic single_req(input int ch, input logic [DIN_W-1:0] d);
        @(negedge clock);
        req_valid = '0;
        req_valid[ch] = 1'b1;
        req_data[ch*DIN_W +: DIN_W] = d;
        out_ready = 1'b1;
        #4;
        acc = req_valid & req_ready;
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        reset     = 1'b1;
        req_valid = '0;
        repeat (n) @(negedge clock);
        #4;
        acc   = '0;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        acc       = '0;
        repeat (3) @(negedge clock);
        #4;
        reset = 1'b0;

        // Single request on ch2 with zero data, then let it drain
        single_req(2, '0);
        run(8, '0, 0, 100);

        // All channels continuously valid, free-flowing output
        run(40, 4'hF, 100, 100);

        // Backpressure: fill, then release
        run(12, 4'hF, 100, 0);
        run(20, 4'hF, 100, 100);
        run(10, '0, 0, 100);

        // Park pointer at 3 via a ch2 grant, then only ch3/ch0 compete
        single_req(2, 16'h1234);
        run(6, '0, 0, 100);
        run(12, 4'b1001, 100, 100);
        run(8, '0, 0, 100);

        // Reset with pipeline and FIFO occupied, then a lone ch1 request
        run(4, 4'hF, 100, 0);
        do_reset(1);
        single_req(1, DIN_W'($urandom));
        run(6, '0, 0, 100);

        // Randomized mixes of request density and backpressure
        run(300, 4'hF, 50, 60);
        run(200, 4'hF, 90, 30);
        run(100, 4'hF, 30, 90);

        // Drain with a bounded wait
        for (int t = 0; t < 40 && (sb.size() != 0 || req_valid != '0); t++) begin
            run(1, '0, 0, 100);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout left=%0d exp=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
